// File: rtl/decade_pkg.sv
// Shared definitions for the cascaded decade counter: controller state
// encoding, the largest legal BCD digit value and the digit increment helper.
package decade_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Next value of a single BCD digit; anything at or above 9 wraps to 0,
    // so a digit can never leave the 0..9 range.
    function automatic logic [3:0] digit_next(input logic [3:0] v);
        logic [3:0] r;
        if (v >= DIGIT_MAX) begin
            r = 4'd0;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decade_digit.sv
// One BCD digit of the chain. Increments on en, clears on clr, and produces
// a carry when it is enabled while already at 9 (that carry enables the next
// more significant digit).
module decade_digit
    import decade_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_r;

    // Digit register: reset and clear dominate, otherwise step on enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r <= 4'd0;
        end else if (clr) begin
            value_r <= 4'd0;
        end else if (en) begin
            value_r <= digit_next(value_r);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
    assign carry = en & (value_r == DIGIT_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run/pause/clear controller driving a chain of BCD decade digits from a
// clock prescaler, with a lap snapshot register and a registered overflow
// pulse on full-chain wrap.
module decade_chain_ctrl
    import decade_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                lap,
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] lap_count,
    output logic                running,
    output logic                overflow
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    state_e              state_r;
    state_e              state_nxt_s;
    logic [15:0]         presc_r;
    logic [15:0]         presc_nxt_s;
    logic                tick_s;
    logic [DIGITS:0]     en_chain_s;
    logic [4*DIGITS-1:0] count_s;
    logic [4*DIGITS-1:0] lap_count_r;
    logic                running_r;
    logic                overflow_r;

    // The tick is only meaningful while running; pause freezes the prescaler.
    assign tick_s        = (state_r == RUN) && (presc_r == PRESC_LAST);
    assign en_chain_s[0] = tick_s;

    // Ripple of enables: digit g steps only when every lower digit is at 9.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        decade_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clear),
            .en    (en_chain_s[g]),
            .value (count_s[4*g +: 4]),
            .carry (en_chain_s[g+1])
        );
    end

    // Next-state logic: clear beats stop, stop beats start.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nxt_s = PAUSE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = PAUSE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Prescaler: counts in RUN, holds in PAUSE, restarts from 0 on a fresh start.
    always_comb begin
        presc_nxt_s = presc_r;
        if (clear) begin
            presc_nxt_s = 16'd0;
        end else if (state_r == RUN) begin
            if (tick_s) begin
                presc_nxt_s = 16'd0;
            end else begin
                presc_nxt_s = presc_r + 16'd1;
            end
        end else if ((state_r == IDLE) && (state_nxt_s == RUN)) begin
            presc_nxt_s = 16'd0;
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Control registers: state, prescaler, running flag and overflow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            presc_r    <= 16'd0;
            running_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            presc_r    <= presc_nxt_s;
            running_r  <= (state_nxt_s == RUN);
            overflow_r <= en_chain_s[DIGITS] & ~clear;
        end
    end

    // Lap snapshot takes the digits as they stand before this edge's update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_count_r <= '0;
        end else if (lap) begin
            lap_count_r <= count_s;
        end else begin
            lap_count_r <= lap_count_r;
        end
    end

    assign count     = count_s;
    assign lap_count = lap_count_r;
    assign running   = running_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Bench for decade_chain_ctrl: a per-cycle scoreboard fed by a decimal
// reference model, a table of command/expectation rows, and hand-written
// sequences for lap, reset and overflow corner cases.
module tb_decade_chain_ctrl;

    localparam int TD = 10;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, clear, lap;
    logic [15:0] count, lap_count;
    logic        running, overflow;

    logic        f_rst_n, f_start, f_zero;
    logic [15:0] f_count, f_lap_count;
    logic        f_running, f_overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] lapv;
        logic        run;
        logic        ovf;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        st, sp, cl, lp;
        int          idle;
        logic [15:0] exp_cnt;
        logic        exp_run;
    } vec_t;
    vec_t vecs[7];

    int   m_cnt, m_lap, m_presc, m_state;
    logic m_ovf;

    always #5 clk = ~clk;

    decade_chain_ctrl #(.DIGITS(4), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .lap(lap), .count(count), .lap_count(lap_count), .running(running),
        .overflow(overflow)
    );

    decade_chain_ctrl #(.DIGITS(4), .TICK_DIV(2)) dut_fast (
        .clk(clk), .rst_n(f_rst_n), .start(f_start), .stop(f_zero), .clear(f_zero),
        .lap(f_zero), .count(f_count), .lap_count(f_lap_count), .running(f_running),
        .overflow(f_overflow)
    );

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        r = 16'd0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive commands, advance the model, then compare after the edge.
    task automatic cyc(input logic st, input logic sp, input logic cl, input logic lp,
                       input logic rn);
        exp_t e;
        logic tick;
        rst_n = rn; start = st; stop = sp; clear = cl; lap = lp;
        if (!rn) begin
            m_cnt = 0; m_lap = 0; m_presc = 0; m_state = 0; m_ovf = 1'b0;
        end else begin
            tick = (m_state == 1) && (m_presc == TD - 1);
            if (lp) m_lap = m_cnt;
            if (cl) begin
                m_cnt = 0; m_presc = 0; m_state = 0; m_ovf = 1'b0;
            end else begin
                m_ovf = tick && (m_cnt == 9999);
                if (tick) m_cnt = (m_cnt + 1) % 10000;
                case (m_state)
                    0: if (st && !sp) begin m_state = 1; m_presc = 0; end
                    1: begin
                        m_presc = tick ? 0 : m_presc + 1;
                        if (sp) m_state = 2;
                    end
                    default: if (st && !sp) m_state = 1;
                endcase
            end
        end
        e.cnt  = to_bcd(m_cnt);
        e.lapv = to_bcd(m_lap);
        e.run  = (m_state == 1);
        e.ovf  = m_ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_count", count, e.cnt);
        chk("sb_lap_count", lap_count, e.lapv);
        chk("sb_running", 16'(running), 16'(e.run));
        chk("sb_overflow", 16'(overflow), 16'(e.ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int   found;
        int   early_ovf;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        f_rst_n = 1'b0; f_start = 1'b0; f_zero = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 100, 16'h0010, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 319, 16'h0042, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 0,   16'h0000, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 5,   16'h0000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 50,  16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,   16'h0000, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   16'h0001, 1'b1};

        // Reset state.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("reset_count", count, 16'h0000);
        chk("reset_running", 16'(running), 16'd0);

        // Table rows: command cycle, idle cycles, then fixed expectations.
        for (int r = 0; r < 7; r++) begin
            cyc(vecs[r].st, vecs[r].sp, vecs[r].cl, vecs[r].lp, 1'b1);
            idle(vecs[r].idle);
            chk($sformatf("vec%0d_count", r), count, vecs[r].exp_cnt);
            chk($sformatf("vec%0d_running", r), 16'(running), 16'(vecs[r].exp_run));
        end

        // Lap on the tick cycle at 0x0019, then clear keeps the snapshot.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(199);
        chk("pre_lap_count", count, 16'h0019);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lap_tick_lap", lap_count, 16'h0019);
        chk("lap_tick_count", count, 16'h0020);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_keeps_lap", lap_count, 16'h0019);
        chk("clear_count", count, 16'h0000);
        chk("clear_running", 16'(running), 16'd0);

        // Reset mid-RUN at 0x0505 beats coincident commands; no tick right after.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5053);
        chk("run_0505", count, 16'h0505);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_count", count, 16'h0000);
        chk("rst_lap", lap_count, 16'h0000);
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_overflow", 16'(overflow), 16'd0);
        idle(1);
        chk("post_rst_count", count, 16'h0000);
        chk("post_rst_running", 16'(running), 16'd0);

        // First tick lands exactly TD cycles after the start edge.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(TD - 1);
        chk("first_tick_before", count, 16'h0000);
        idle(1);
        chk("first_tick_at", count, 16'h0001);

        // Full-chain wrap on the fast instance.
        @(posedge clk); #1;
        f_rst_n = 1'b1; f_start = 1'b1;
        @(posedge clk); #1;
        f_start = 1'b0;
        chk("fast_running", 16'(f_running), 16'd1);
        found = 0;
        early_ovf = 0;
        for (int i = 0; i < 25000 && found == 0; i++) begin
            @(posedge clk); #1;
            if (f_overflow) early_ovf++;
            if (f_count == 16'h9998) found = 1;
        end
        chk("fast_reach_9998", 16'(found), 16'd1);
        chk("fast_no_early_ovf", 16'(early_ovf), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("fast_9999", f_count, 16'h9999);
        chk("fast_9999_ovf", 16'(f_overflow), 16'd0);
        @(posedge clk); #1;
        chk("fast_9999_hold", f_count, 16'h9999);
        @(posedge clk); #1;
        chk("fast_wrap_count", f_count, 16'h0000);
        chk("fast_wrap_ovf", 16'(f_overflow), 16'd1);
        @(posedge clk); #1;
        chk("fast_ovf_one_cycle", 16'(f_overflow), 16'd0);
        chk("fast_still_running", 16'(f_running), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
